// File: rtl/gpc_sum_accumulator.sv
// -----------------------------------------------------------------------------
// gpc_sum_accumulator
//   Folds a stream of GPC compressor result words into one weighted sum.
//   Each accepted word is shifted left by its column weight and added into an
//   AW-bit accumulator. When the beat tagged last is accepted, the final sum,
//   the beat count and a sticky overflow flag are presented, then held until
//   the downstream handshake completes.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream word valid
//   in_ready   block can accept a word (low while a result is held)
//   in_data    GPC result word [DW-1:0]
//   in_shift   column weight shift [SW-1:0]
//   in_last    final word of the current operation
//   out_valid  out_sum / out_count / overflow are valid
//   out_ready  downstream accepts the result
//   out_sum    final accumulated sum [AW-1:0]
//   out_count  accepted beats including last, saturating [CW-1:0]
//   overflow   sticky: the true sum did not fit in AW bits
//
// Configuration macro
//   GPC_SUM_ACCUMULATOR_SATURATE_EN : when defined the accumulator clamps to
//   all-ones on overflow and stays there for the rest of the operation;
//   otherwise it wraps modulo 2^AW.
// -----------------------------------------------------------------------------
module gpc_sum_accumulator #(
    parameter int DW = 5,
    parameter int SW = 3,
    parameter int AW = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [SW-1:0] in_shift,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum,
    output logic [CW-1:0] out_count,
    output logic          overflow
);

    // Full width of a shifted term: nothing is lost before the add.
    localparam int TW = DW + (1 << SW) - 1;
    // Add width: one guard bit above the wider operand catches the carry.
    localparam int XW = ((AW > TW) ? AW : TW) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state_r;
    logic [AW-1:0]   acc_r;
    logic [CW-1:0]   count_r;
    logic            ovf_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [AW-1:0]   out_sum_r;
    logic [CW-1:0]   out_count_r;
    logic            overflow_r;

    logic            accept_s;
    logic [TW-1:0]   term_s;
    logic [XW-1:0]   sum_s;
    logic            carry_s;
    logic [AW-1:0]   next_acc_s;
    logic [CW-1:0]   next_count_s;

    // Zero-extends both operands to the guarded add width and sums them.
    function automatic logic [XW-1:0] wide_add(input logic [AW-1:0] acc,
                                               input logic [TW-1:0] term);
        logic [XW-1:0] a;
        logic [XW-1:0] b;
        a = {{(XW-AW){1'b0}}, acc};
        b = {{(XW-TW){1'b0}}, term};
        return a + b;
    endfunction

    // Saturating increment of the beat counter.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
        if (cnt == {CW{1'b1}}) begin
            return cnt;
        end else begin
            return cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    endfunction

    // Datapath for one beat: shifted term, guarded add, next accumulator/count.
    always_comb begin
        accept_s     = in_valid && in_ready_r;
        term_s       = {{(TW-DW){1'b0}}, in_data} << in_shift;
        sum_s        = wide_add(acc_r, term_s);
        // Any bit at or above AW means the true sum no longer fits.
        carry_s      = |sum_s[XW-1:AW];
        next_count_s = sat_inc(count_r);
`ifdef GPC_SUM_ACCUMULATOR_SATURATE_EN
        // Once clamped, stay clamped until the operation ends.
        if (carry_s || ovf_r) begin
            next_acc_s = {AW{1'b1}};
        end else begin
            next_acc_s = sum_s[AW-1:0];
        end
`else
        next_acc_s   = sum_s[AW-1:0];
`endif
    end

    // Control FSM with accumulator state and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_sum_r   <= {AW{1'b0}};
            out_count_r <= {CW{1'b0}};
            overflow_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, ACCUM: begin
                    if (accept_s) begin
                        acc_r   <= next_acc_s;
                        count_r <= next_count_s;
                        ovf_r   <= ovf_r | carry_s;
                        if (in_last) begin
                            state_r     <= HOLD;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_sum_r   <= next_acc_s;
                            out_count_r <= next_count_s;
                            overflow_r  <= ovf_r | carry_s;
                        end else begin
                            state_r <= ACCUM;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        acc_r       <= {AW{1'b0}};
                        count_r     <= {CW{1'b0}};
                        ovf_r       <= 1'b0;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        out_sum_r   <= {AW{1'b0}};
                        out_count_r <= {CW{1'b0}};
                        overflow_r  <= 1'b0;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    acc_r       <= {AW{1'b0}};
                    count_r     <= {CW{1'b0}};
                    ovf_r       <= 1'b0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    out_sum_r   <= {AW{1'b0}};
                    out_count_r <= {CW{1'b0}};
                    overflow_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_count = out_count_r;
    assign overflow  = overflow_r;

endmodule
